// File: rtl/kb_char_queue.sv
// kb_char_queue
//   Turns raw PS/2 set-2 scan codes into a buffered ASCII character stream.
//   Break (F0) and extended (E0) sequences are stripped. Make codes are
//   translated to ASCII and pushed into a first-word-fall-through FIFO.
//
// Ports
//   clk             system clock
//   reset           asynchronous, active-low reset
//   scan_code       scan code from the keyboard receiver
//   scan_code_ready code-complete strobe; only its rising edge is used
//   letter_case     1 = upper-case letters, latched together with the code
//   rd_en           pop request; ignored while the FIFO is empty
//   char_out        ASCII character at the FIFO head, 0x00 when empty
//   char_valid      FIFO not empty
//   full            FIFO full
//   count           FIFO occupancy (0 .. 2**DEPTH_LOG2)
//   overflow        sticky; a character was dropped on a full FIFO
//
// Build option
//   KB_CHAR_QUEUE_TYPEMATIC_FILTER_EN : suppress keyboard auto-repeat. A make
//   code equal to the last pushed code is dropped until its break is seen.
module kb_char_queue #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [7:0]          scan_code,
    input  logic                scan_code_ready,
    input  logic                letter_case,
    input  logic                rd_en,
    output logic [7:0]          char_out,
    output logic                char_valid,
    output logic                full,
    output logic [DEPTH_LOG2:0] count,
    output logic                overflow
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {IDLE, BREAK, EXT, EXT_BREAK} state_t;

    typedef struct packed {
        logic [7:0] code;
        logic       upper;
    } cap_t;

    // Returns {mapped, ascii}. Letters are listed lower case and flipped
    // to upper case by clearing bit 5.
    function automatic logic [8:0] xlate(input logic [7:0] c, input logic up);
        logic [7:0] a;
        logic       m;
        a = 8'h00;
        m = 1'b1;
        case (c)
            8'h1C: a = "a";  8'h32: a = "b";  8'h21: a = "c";  8'h23: a = "d";
            8'h24: a = "e";  8'h2B: a = "f";  8'h34: a = "g";  8'h33: a = "h";
            8'h43: a = "i";  8'h3B: a = "j";  8'h42: a = "k";  8'h4B: a = "l";
            8'h3A: a = "m";  8'h31: a = "n";  8'h44: a = "o";  8'h4D: a = "p";
            8'h15: a = "q";  8'h2D: a = "r";  8'h1B: a = "s";  8'h2C: a = "t";
            8'h3C: a = "u";  8'h2A: a = "v";  8'h1D: a = "w";  8'h22: a = "x";
            8'h35: a = "y";  8'h1A: a = "z";
            8'h45: a = "0";  8'h16: a = "1";  8'h1E: a = "2";  8'h26: a = "3";
            8'h25: a = "4";  8'h2E: a = "5";  8'h36: a = "6";  8'h3D: a = "7";
            8'h3E: a = "8";  8'h46: a = "9";
            8'h29: a = 8'h20;
            8'h5A: a = 8'h0D;
            8'h66: a = 8'h08;
            default: m = 1'b0;
        endcase
        if (up && a >= 8'h61) a = a & 8'hDF;
        return {m, a};
    endfunction

    logic                  ready_q;
    logic                  pend;
    cap_t                  cap;
    state_t                state;
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [7:0]            mem [DEPTH];
    logic                  accept, mapped, push, pop, push_ok;
    logic [7:0]            ascii;
`ifdef KB_CHAR_QUEUE_TYPEMATIC_FILTER_EN
    logic [7:0]            rep;
`endif

    assign accept = scan_code_ready & ~ready_q;

    always_comb begin
        {mapped, ascii} = xlate(cap.code, cap.upper);
        // F0/E0 are not in the table, so mapped already excludes prefixes.
        push = pend && (state == IDLE) && mapped;
`ifdef KB_CHAR_QUEUE_TYPEMATIC_FILTER_EN
        if (cap.code == rep) push = 1'b0;
`endif
    end

    assign char_valid = (count != '0);
    assign full       = count[DEPTH_LOG2];
    assign char_out   = char_valid ? mem[rd_ptr] : 8'h00;
    assign pop        = rd_en & char_valid;
    // A full FIFO still accepts a push when a pop frees a slot on the same edge.
    assign push_ok    = push & (~full | pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ready_q  <= 1'b0;
            pend     <= 1'b0;
            cap      <= '0;
            state    <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
`ifdef KB_CHAR_QUEUE_TYPEMATIC_FILTER_EN
            rep      <= 8'h00;
`endif
        end else begin
            ready_q <= scan_code_ready;
            pend    <= accept;
            if (accept) cap <= '{code: scan_code, upper: letter_case};

            if (pend) begin
                case (state)
                    IDLE: begin
                        if (cap.code == 8'hF0)      state <= BREAK;
                        else if (cap.code == 8'hE0) state <= EXT;
`ifdef KB_CHAR_QUEUE_TYPEMATIC_FILTER_EN
                        else if (mapped)            rep   <= cap.code;
`endif
                    end
                    BREAK: begin
                        state <= IDLE;
`ifdef KB_CHAR_QUEUE_TYPEMATIC_FILTER_EN
                        if (cap.code == rep) rep <= 8'h00;
`endif
                    end
                    EXT:       state <= (cap.code == 8'hF0) ? EXT_BREAK : IDLE;
                    default:   state <= IDLE;
                endcase
            end

            if (push && !push_ok) overflow <= 1'b1;
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= ascii;
    end
endmodule

// File: tb/tb_kb_char_queue.sv
module tb_kb_char_queue;
    localparam int DL = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  scan_code = 8'h00;
    logic        scan_code_ready = 1'b0;
    logic        letter_case = 1'b0;
    logic        rd_en = 1'b0;
    logic [7:0]  char_out;
    logic        char_valid, full, overflow;
    logic [DL:0] count;

    int checks = 0;
    int fails  = 0;
    logic [7:0] exp_q [$];
    logic [7:0] letters [17] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                                 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
                                 8'h15};

    always #5 clk = ~clk;

    kb_char_queue #(.DEPTH_LOG2(DL)) dut (
        .clk(clk), .reset(reset), .scan_code(scan_code),
        .scan_code_ready(scan_code_ready), .letter_case(letter_case),
        .rd_en(rd_en), .char_out(char_out), .char_valid(char_valid),
        .full(full), .count(count), .overflow(overflow)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted pop is checked against the scoreboard head.
    always @(negedge clk) begin
        if (reset && rd_en && char_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL pop_unexpected: got 0x%0h expected no character", char_out);
            end else begin
                chk("pop_data", {8'h00, char_out}, {8'h00, exp_q.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] code, input logic lc);
        tick();
        scan_code = code;
        letter_case = lc;
        scan_code_ready = 1'b1;
        tick();
        scan_code_ready = 1'b0;
        tick();
    endtask

    task automatic pop_n(input int n);
        rd_en = 1'b1;
        repeat (n) tick();
        rd_en = 1'b0;
        tick();
    endtask

    task automatic pulse_reset();
        tick();
        reset = 1'b0;
        #1;
        chk("rst_count", 16'(count), 16'd0);
        chk("rst_overflow", 16'(overflow), 16'd0);
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    initial begin
        // Reset state
        tick();
        chk("reset_char_out", 16'(char_out), 16'h00);
        chk("reset_valid", 16'(char_valid), 16'd0);
        chk("reset_full", 16'(full), 16'd0);
        chk("reset_count", 16'(count), 16'd0);
        chk("reset_overflow", 16'(overflow), 16'd0);
        reset = 1'b1;
        tick();

        // Single lower-case letter, then pop back to empty
        exp_q.push_back(8'h61);
        send(8'h1C, 1'b0);
        chk("first_valid", 16'(char_valid), 16'd1);
        chk("first_char", 16'(char_out), 16'h61);
        chk("first_count", 16'(count), 16'd1);
        pop_n(1);
        chk("empty_valid", 16'(char_valid), 16'd0);
        chk("empty_char", 16'(char_out), 16'h00);

        // Break and extended sequences are stripped
        exp_q.push_back(8'h41);
        send(8'h1C, 1'b1);
        send(8'hF0, 1'b1);
        send(8'h1C, 1'b1);
        exp_q.push_back(8'h30);
        send(8'h45, 1'b1);
        chk("break_count", 16'(count), 16'd2);
        send(8'hE0, 1'b0);
        send(8'h75, 1'b0);
        send(8'hE0, 1'b0);
        send(8'hF0, 1'b0);
        send(8'h75, 1'b0);
        chk("ext_count", 16'(count), 16'd2);
        exp_q.push_back(8'h61);
        send(8'h1C, 1'b0);
        chk("idle_after_ext", 16'(count), 16'd3);
        pop_n(3);

        // Overflow: 17 distinct codes into 16 slots
        for (int i = 0; i < 17; i++) begin
            if (i < 16) exp_q.push_back(8'h61 + 8'(i));
            send(letters[i], 1'b0);
        end
        chk("ovf_full", 16'(full), 16'd1);
        chk("ovf_count", 16'(count), 16'd16);
        chk("ovf_flag", 16'(overflow), 16'd1);
        pop_n(16);
        chk("drain_count", 16'(count), 16'd0);
        chk("ovf_sticky", 16'(overflow), 16'd1);

        // Push and pop on the same edge while full
        pulse_reset();
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(8'h41 + 8'(i));
            send(letters[i], 1'b1);
        end
        tick();
        scan_code = 8'h29;
        scan_code_ready = 1'b1;
        tick();
        scan_code_ready = 1'b0;
        rd_en = 1'b1;
        exp_q.push_back(8'h20);
        tick();
        rd_en = 1'b0;
        tick();
        chk("pp_count", 16'(count), 16'd16);
        chk("pp_overflow", 16'(overflow), 16'd0);
        chk("pp_full", 16'(full), 16'd1);
        pop_n(16);

        // Typematic repeat sequence
        exp_q.push_back(8'h61);
        send(8'h1C, 1'b0);
`ifndef KB_CHAR_QUEUE_TYPEMATIC_FILTER_EN
        exp_q.push_back(8'h61);
`endif
        send(8'h1C, 1'b0);
        send(8'hF0, 1'b0);
        send(8'h1C, 1'b0);
        exp_q.push_back(8'h61);
        send(8'h1C, 1'b0);
`ifdef KB_CHAR_QUEUE_TYPEMATIC_FILTER_EN
        chk("typematic_count", 16'(count), 16'd2);
`else
        chk("typematic_count", 16'(count), 16'd3);
`endif
        pop_n(int'(count));

        // Held strobe yields one push
        tick();
        scan_code = 8'h32;
        letter_case = 1'b0;
        scan_code_ready = 1'b1;
        exp_q.push_back(8'h62);
        repeat (10) tick();
        scan_code_ready = 1'b0;
        tick();
        tick();
        chk("held_count", 16'(count), 16'd1);
        pop_n(1);

        // Reset after F0 discards the prefix
        send(8'hF0, 1'b0);
        pulse_reset();
        exp_q.push_back(8'h61);
        send(8'h1C, 1'b0);
        chk("post_reset_count", 16'(count), 16'd1);
        chk("post_reset_char", 16'(char_out), 16'h61);
        pop_n(1);

        chk("scoreboard_empty", 16'(exp_q.size()), 16'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/kb_char_queue.md
# kb_char_queue

Downstream consumer of the PS/2 `keyboard` receiver. It takes raw set-2 scan codes plus the upper-case flag, strips break (`F0`) and extended (`E0`) sequences, and translates make codes to ASCII. Characters go into a first-word-fall-through FIFO that the notepad/text engine pops at its own pace. It replaces the direct LED display of `scan_code` with a buffered character stream.

## Interface
Parameters:
- `DEPTH_LOG2`, default 4: FIFO holds 2^DEPTH_LOG2 characters.

Ports:
- `clk`  in  1  system clock (CLOCK_50).
- `reset`  in  1  one clock; reset is asynchronous and active-low.
- `scan_code`  in  8  scan code from `keyboard`; valid when `scan_code_ready` rises.
- `scan_code_ready`  in  1  code-complete strobe from `keyboard`; may be held high for several cycles.
- `letter_case`  in  1  1 = upper case (from `letter_case_out`).
- `rd_en`  in  1  pop request from consumer.
- `char_out`  out  8  ASCII at FIFO head; 0x00 when empty.
- `char_valid`  out  1  FIFO not empty.
- `full`  out  1  FIFO full.
- `count`  out  DEPTH_LOG2+1  occupancy.
- `overflow`  out  1  sticky; a character was dropped because the FIFO was full.

## Operation
- Reset (`reset`=0, asynchronous): FIFO empty, `char_out`=0x00, `char_valid`=0, `full`=0, `count`=0, `overflow`=0, decoder in IDLE, edge register 0, capture pending cleared, repeat memory 0x00.
- Edge detect: a code is accepted on a clock edge where `scan_code_ready`=1 and the registered previous value is 0. `scan_code` and `letter_case` are latched on that edge. A held strobe yields one acceptance.
- Decoder FSM, advanced once per accepted code:
  - IDLE: `F0`→BREAK; `E0`→EXT; any other code → translate, stay IDLE.
  - BREAK: any code → IDLE, nothing pushed.
  - EXT: `F0`→EXT_BREAK; any other code → IDLE, nothing pushed (extended keys unsupported).
  - EXT_BREAK: any code → IDLE, nothing pushed.
- Translation (set 2 → ASCII):
  - Letters: 1C a, 32 b, 21 c, 23 d, 24 e, 2B f, 34 g, 33 h, 43 i, 3B j, 42 k, 4B l, 3A m, 31 n, 44 o, 4D p, 15 q, 2D r, 1B s, 2C t, 3C u, 2A v, 1D w, 22 x, 35 y, 1A z.
  - Letters are lower case (0x61–0x7A) when latched `letter_case`=0 and upper case (0x41–0x5A) when it is 1.
  - Digits are unaffected by case: 45 '0', 16 '1', 1E '2', 26 '3', 25 '4', 2E '5', 36 '6', 3D '7', 3E '8', 46 '9'.
  - Controls: 29 → 0x20, 5A → 0x0D, 66 → 0x08.
  - Any other code in IDLE is dropped silently.
- FIFO: circular buffer; read and write pointers are DEPTH_LOG2 bits wide and wrap modulo depth.
  - Pop occurs when `rd_en`=1 and `char_valid`=1. `rd_en` on an empty FIFO is ignored.
  - A push on full with no pop in the same cycle: character dropped, `overflow` set to 1. `overflow` clears only on reset.
  - Push and pop in the same cycle while full: both succeed, `count` unchanged.
  - Push and pop in the same cycle while empty: the push succeeds and the pop is ignored.

## Timing
- Accept edge E: the code is latched. Edge E+1: decode, translate, push.
- `char_valid`, `char_out`, `count` and `full` reflect the push after E+1. Latency is 2 edges from the strobe being sampled high.
- Pop: `char_out` shows the next entry and `count` decrements immediately after the popping edge.
- Back-to-back accepted codes are handled at one per 2 cycles minimum. The strobe must be low for at least one cycle between codes; PS/2 rates guarantee thousands.
- Reset asserted mid-sequence: a pending capture is discarded and a partially received F0/E0 prefix is lost.

## Configuration
- `KB_CHAR_QUEUE_TYPEMATIC_FILTER_EN` defined: auto-repeat suppression.
  - In IDLE, a mapped make code equal to the repeat memory is dropped.
  - Otherwise the character is pushed and the repeat memory is loaded with the code.
  - In BREAK, a code equal to the repeat memory clears it to 0x00.
- Not defined: no repeat memory; every mapped make code is pushed.

## Test plan
- Reset, `letter_case`=0, strobe with code 1C → 2 edges later `char_valid`=1, `char_out`=0x61, `count`=1. Pop → `char_valid`=0, `char_out`=0x00.
- Sequence 1C, F0 1C with `letter_case`=1, then 45 → FIFO holds 0x41, 0x30 only. E0 75, then E0 F0 75 → nothing pushed, FSM back in IDLE.
- DEPTH_LOG2=4, 17 distinct mapped codes with no pops → `full`=1, `count`=16, `overflow`=1. Pops return the first 16 in order, and the pointers wrap.
- FIFO full, strobe with code 29 in the same cycle as `rd_en`=1 → `count` stays 16, `overflow` stays 0, and 0x20 is read last.
- Codes 1C, 1C, F0 1C, 1C → 2 characters with `KB_CHAR_QUEUE_TYPEMATIC_FILTER_EN` defined, 3 without.
- `scan_code_ready` held high for 10 cycles → one push. `reset` pulsed low after F0 → the next 1C is pushed as 0x61.
